// File: rtl/bias_grad_accumulator_pkg.sv
// Shared Q8.8 fixed-point definitions and saturation helpers used by the
// fxp datapath blocks.
package bias_grad_accumulator_pkg;

   localparam int FRAC_BITS = 8;
   localparam int Q_W       = 16;
   // Width of the value handed to the saturation helpers; wide enough for
   // any accumulator in the fxp blocks.
   localparam int SAT_IN_W  = 32;

   typedef logic signed [Q_W-1:0] q8_8_t;

   localparam q8_8_t Q_MAX = 16'h7FFF;
   localparam q8_8_t Q_MIN = 16'h8000;

   // True when v cannot be represented as a Q8.8 word.
   function automatic logic q_out_of_range(input logic signed [SAT_IN_W-1:0] v);
      logic signed [SAT_IN_W-1:0] hi;
      logic signed [SAT_IN_W-1:0] lo;
      hi = SAT_IN_W'(Q_MAX);
      lo = SAT_IN_W'(Q_MIN);
      return (v > hi) || (v < lo);
   endfunction

   // Clamp a wide signed value to the Q8.8 range.
   function automatic q8_8_t sat_q8_8(input logic signed [SAT_IN_W-1:0] v);
      logic signed [SAT_IN_W-1:0] hi;
      logic signed [SAT_IN_W-1:0] lo;
      hi = SAT_IN_W'(Q_MAX);
      lo = SAT_IN_W'(Q_MIN);
      if (v > hi)
         return Q_MAX;
      else if (v < lo)
         return Q_MIN;
      else
         return v[Q_W-1:0];
   endfunction

endpackage

// File: rtl/bias_grad_accumulator.sv
// Per-lane batch reduction of Q8.8 bias gradients: sums a batch of samples,
// optionally averages by an arithmetic right shift, and emits a saturated
// result with a one-cycle valid pulse for the update stage.
module bias_grad_accumulator
   import bias_grad_accumulator_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int BATCH_W = 8,
   parameter int ACC_W   = DATA_W + BATCH_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_in,
   input  logic [BATCH_W-1:0] batch_size_in,
   input  logic [2:0]         avg_shift_in,
   input  logic [DATA_W-1:0]  grad_in,
   input  logic               grad_valid_in,
   output logic               busy_out,
   output logic [DATA_W-1:0]  grad_sum_out,
   output logic               grad_sum_valid_out,
   output logic               overflow_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                    state_q;
   state_t                    state_d;

   logic signed [ACC_W-1:0]   acc;
   logic [BATCH_W-1:0]        count;
   logic [2:0]                shift;

   logic                      accept_start;
   logic                      take_sample;
   logic                      last_sample;

   logic signed [ACC_W-1:0]   grad_ext;
   logic signed [ACC_W-1:0]   acc_sum;
   logic signed [ACC_W-1:0]   avg_val;
   logic signed [SAT_IN_W-1:0] sat_in;

   // Averaging is a plain arithmetic shift, so the result truncates toward -inf.
   function automatic logic signed [ACC_W-1:0] avg_shift(
      input logic signed [ACC_W-1:0] v,
      input logic [2:0]              sh
   );
      return v >>> sh;
   endfunction

   assign accept_start = (state_q == IDLE) && start_in && (batch_size_in != '0);
   assign take_sample  = (state_q == ACCUM) && grad_valid_in;
   assign last_sample  = take_sample && (count == BATCH_W'(1));

   // The accumulator is DATA_W+BATCH_W wide, so the running sum never wraps;
   // saturation only happens once, after the averaging shift.
   assign grad_ext = ACC_W'(signed'(grad_in));
   assign acc_sum  = acc + grad_ext;
   assign avg_val  = avg_shift(acc_sum, shift);
   assign sat_in   = SAT_IN_W'(avg_val);

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic: DONE always lasts exactly one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_start) state_d = ACCUM;
         ACCUM:   if (last_sample)  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Batch accumulation, result capture and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc                <= '0;
         count              <= '0;
         shift              <= '0;
         busy_out           <= 1'b0;
         grad_sum_out       <= '0;
         grad_sum_valid_out <= 1'b0;
         overflow_out       <= 1'b0;
      end else begin
         busy_out           <= (state_d != IDLE);
         grad_sum_valid_out <= 1'b0;
         if (accept_start) begin
            acc          <= '0;
            count        <= batch_size_in;
            shift        <= avg_shift_in;
            overflow_out <= 1'b0;
         end else if (take_sample) begin
            acc   <= acc_sum;
            count <= count - BATCH_W'(1);
            if (last_sample) begin
               grad_sum_out       <= DATA_W'(sat_q8_8(sat_in));
               grad_sum_valid_out <= 1'b1;
               overflow_out       <= q_out_of_range(sat_in);
            end
         end
      end
   end

endmodule

// File: doc/bias_grad_accumulator.md
Name: bias_grad_accumulator

Overview:
- Per-lane batch reduction stage directly upstream of the gradient-descent update stage.
- Sums a batch of Q8.8 bias gradients (dL/dZ rows streamed from the systolic/VPU path) into one gradient value.
- Optionally averages the sum by an arithmetic right shift.
- Emits a saturated 16-bit result with a one-cycle valid pulse that drives the update stage's grad_in / valid inputs.

Parameters:
- DATA_W, 16, fixed-point word width (Q8.8 signed).
- BATCH_W, 8, width of the batch-size field; max batch 2^BATCH_W-1.
- ACC_W, DATA_W+BATCH_W, internal accumulator width (signed); guarantees no internal wrap.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start_in  input  1  begin a new batch; sampled only in IDLE.
- batch_size_in  input  BATCH_W  number of gradients to sum; sampled with start_in.
- avg_shift_in  input  3  arithmetic right shift applied to the final sum; sampled with start_in.
- grad_in  input  DATA_W  signed Q8.8 gradient sample.
- grad_valid_in  input  1  grad_in carries a sample this cycle.
- busy_out  output  1  high in ACCUM and DONE.
- grad_sum_out  output  DATA_W  saturated Q8.8 reduced gradient.
- grad_sum_valid_out  output  1  one-cycle pulse; grad_sum_out valid.
- overflow_out  output  1  result saturated in the last batch; sticky until next accepted start.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; all state is updated only on rising clk.
- Reset values:
  - state = IDLE; acc = 0; count = 0; shift register = 0.
  - busy_out = 0; grad_sum_out = 0; grad_sum_valid_out = 0; overflow_out = 0.
- States: IDLE, ACCUM, DONE.

IDLE:
- grad_valid_in is ignored (sample dropped).
- On start_in=1 with batch_size_in != 0:
  - acc <= 0; count <= batch_size_in; shift <= avg_shift_in; overflow_out <= 0.
  - Next state is ACCUM.
- On start_in=1 with batch_size_in == 0: no-op, remain IDLE, outputs unchanged.

ACCUM:
- Each cycle with grad_valid_in=1:
  - acc <= acc + sign_extend(grad_in).
  - count <= count-1.
- Cycles with grad_valid_in=0 are stalls: no change.
- start_in is ignored.
- When grad_valid_in=1 and count==1 (last sample):
  - Compute final = (acc + sext(grad_in)) >>> shift (arithmetic, truncating toward -inf).
  - Register grad_sum_out <= sat16(final), grad_sum_valid_out <= 1, overflow_out <= (final outside [-32768, 32767]).
  - Next state is DONE.

DONE:
- Lasts one cycle; grad_sum_valid_out is high in this cycle only.
- Next state is IDLE; grad_sum_valid_out <= 0.
- start_in and grad_valid_in in DONE are ignored. A back-to-back batch may be started in the cycle after DONE.

Timing and output rules:
- Latency: grad_sum_valid_out is high in the cycle immediately following the cycle in which the last sample was presented.
- grad_sum_out holds its value after the pulse until the next result or reset.
- Saturation: clamp to 0x7FFF / 0x8000. sat16 is applied after the shift.
- busy_out = (state != IDLE), registered from the state.
- rst asserted mid-batch: the partial sum is discarded, all reset values apply on the next edge, and no valid pulse is produced.

Decomposition:
- Shared fixed-point package holds:
  - Q8.8 word typedef.
  - FRAC_BITS = 8.
  - Q_MAX = 16'h7FFF and Q_MIN = 16'h8000.
  - A saturate-to-DATA_W function, reused by other fxp blocks.
- FSM state enum is local to the module.
- No sub-module is needed; the accumulate/shift/saturate datapath is small enough to stay inline.

Test Plan:
- Start, batch 4, shift 0; samples 0x0100 ×4 back-to-back -> one valid pulse in the cycle after the 4th sample, grad_sum_out=0x0400, overflow_out=0, busy_out low the cycle after the pulse.
- Batch 4, shift 2; samples 0x0100, 0x0200, 0x0300, 0x0200 with valid gaps of 0-3 cycles between them -> grad_sum_out=0x0200, exactly one pulse, timed one cycle after the last valid.
- Batch 4, shift 0; samples 0xFF80 ×3 then 0x0100 -> 0xFF80 (-0.5). Batch 2, shift 1; samples 0xFF00, 0x0000 -> 0xFF80.
- Batch 4; samples 0x7000 ×4 -> grad_sum_out=0x7FFF, overflow_out=1. Then batch 1 with sample 0x0001 -> 0x0001, overflow_out cleared at start.
- Stray inputs: grad_valid_in pulses in IDLE and start_in pulses during ACCUM -> no effect on sum or timing. start with batch_size_in=0 -> no busy, no pulse.
- Assert rst for one cycle after 2 of 4 samples -> all outputs 0, state IDLE. A fresh batch of 2 × 0x0100 -> 0x0200 with no residue from the aborted batch.
